// File: rtl/run_control.sv
// -----------------------------------------------------------------------------
// run_control
//   Run/stop/single-step sequencer for a five-phase instruction engine. It
//   gates the phase counter through 'enable', detects instruction boundaries
//   (last phase while enabled), counts retired instructions and latches a
//   sticky error on any malformed phase code.
//
// Ports
//   clk        : single clock, rising-edge
//   rst_n      : asynchronous active-low reset
//   start      : level request to run freely (rising edge acts)
//   stop       : level request to stop at the next boundary (rising edge acts)
//   step       : level request to execute one instruction (rising edge acts)
//   halt_req   : current last-phase instruction is a halt
//   cur_phase  : one-hot phase from the phase counter (00000 after reset)
//   enable     : advance enable to the phase counter
//   halted     : high in HALT
//   step_done  : one-cycle pulse when a single step retires
//   instr_cnt  : retired-instruction count, wraps
//   phase_err  : sticky illegal-phase flag
// -----------------------------------------------------------------------------
module run_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             halt_req,
  input  logic [4:0]       cur_phase,
  output logic             enable,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             phase_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   step_done_nxt;

  // Previous-sample registers come out of reset high so a request held
  // through reset does not register as a fresh edge.
  logic start_q, stop_q, step_q;
  logic start_p, stop_p, step_p;

  logic phase_onehot;
  logic phase_bad;
  logic boundary;

  assign start_p = start & ~start_q;
  assign stop_p  = stop  & ~stop_q;
  assign step_p  = step  & ~step_q;

  assign phase_onehot = (cur_phase != 5'd0) &&
                        ((cur_phase & (cur_phase - 5'd1)) == 5'd0);
  assign phase_bad    = (cur_phase != 5'd0) && !phase_onehot;

  assign enable = (state == RUN) || (state == STEP) || (state == DRAIN);
  assign halted = (state == HALT);

  // Exact compare: a malformed code with bit 4 set is never a boundary.
  assign boundary = enable && (cur_phase == 5'b10000);

  always_comb begin
    state_nxt     = state;
    step_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start_p)     state_nxt = RUN;
        else if (step_p) state_nxt = STEP;
      end
      RUN: begin
        if (boundary && halt_req) state_nxt = HALT;
        else if (stop_p)          state_nxt = boundary ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (boundary && halt_req) state_nxt = HALT;
        else if (boundary)        state_nxt = IDLE;
        else if (start_p)         state_nxt = RUN;
      end
      STEP: begin
        if (boundary && halt_req) begin
          state_nxt = HALT;
        end else if (boundary) begin
          state_nxt     = IDLE;
          step_done_nxt = 1'b1;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step_done <= 1'b0;
      instr_cnt <= '0;
      phase_err <= 1'b0;
      start_q   <= 1'b1;
      stop_q    <= 1'b1;
      step_q    <= 1'b1;
    end else begin
      state     <= state_nxt;
      step_done <= step_done_nxt;
      start_q   <= start;
      stop_q    <= stop;
      step_q    <= step;
      if (boundary)  instr_cnt <= instr_cnt + CNT_W'(1);
      if (phase_bad) phase_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_run_control.sv
// -----------------------------------------------------------------------------
// tb_run_control
//   Directed bench for run_control. A behavioural phase counter follows the
//   DUT's enable; an override lets a single malformed phase code be injected.
//   A second instance with a 4-bit counter shares all inputs to show wrap.
// -----------------------------------------------------------------------------
module tb_run_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, step, halt_req;
  logic [4:0]  cur_phase;
  logic        enable, halted, step_done, phase_err;
  logic [15:0] instr_cnt;
  logic        enable4, halted4, step_done4, phase_err4;
  logic [3:0]  instr_cnt4;

  logic [4:0]  phase_cnt;
  logic        ovr;
  logic [4:0]  ovr_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_control #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
    .halt_req(halt_req), .cur_phase(cur_phase), .enable(enable),
    .halted(halted), .step_done(step_done), .instr_cnt(instr_cnt),
    .phase_err(phase_err)
  );

  run_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
    .halt_req(halt_req), .cur_phase(cur_phase), .enable(enable4),
    .halted(halted4), .step_done(step_done4), .instr_cnt(instr_cnt4),
    .phase_err(phase_err4)
  );

  // Model phase counter: 00000 after reset, then 00001..10000 cyclically.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase_cnt <= 5'd0;
    else if (enable && !ovr)
      phase_cnt <= (phase_cnt == 5'b10000 || phase_cnt == 5'd0) ? 5'b00001
                                                                 : (phase_cnt << 1);
  end

  assign cur_phase = ovr ? ovr_val : phase_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles with enable high, starting from the current cycle.
  task automatic run_enable(output int n, output logic done_at_exit);
    n = 0;
    while (enable === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    done_at_exit = step_done;
  endtask

  task automatic wait_phase(input logic [4:0] p, output logic ok);
    int i;
    i = 0;
    while (cur_phase !== p && i < 20) begin
      tick();
      i++;
    end
    ok = (cur_phase === p);
  endtask

  initial begin
    int   n;
    logic d;
    logic ok;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; halt_req = 1'b0;
    ovr = 1'b0; ovr_val = 5'd0;

    // Reset state before any clock edge
    #3;
    chk("rst_enable",    32'(enable),    32'd0);
    chk("rst_halted",    32'(halted),    32'd0);
    chk("rst_step_done", 32'(step_done), 32'd0);
    chk("rst_cnt",       32'(instr_cnt), 32'd0);
    chk("rst_phase_err", 32'(phase_err), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // First step from phase 00000: 6 enabled cycles
    step = 1'b1; tick(); step = 1'b0;
    run_enable(n, d);
    chk("step1_cycles", 32'(n), 32'd6);
    chk("step1_done",   32'(d), 32'd1);
    chk("step1_cnt",    32'(instr_cnt), 32'd1);
    tick();
    chk("step1_done_pulse", 32'(step_done), 32'd0);

    // Second step: 5 enabled cycles
    step = 1'b1; tick(); step = 1'b0;
    run_enable(n, d);
    chk("step2_cycles", 32'(n), 32'd5);
    chk("step2_done",   32'(d), 32'd1);
    chk("step2_cnt",    32'(instr_cnt), 32'd2);

    // Run, stop at phase 00100 -> drain to boundary
    start = 1'b1; tick(); start = 1'b0;
    chk("run_enable", 32'(enable), 32'd1);
    tick(); tick();
    chk("drain_phase", 32'(cur_phase), 32'h04);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("drain_en_a", 32'(enable), 32'd1);
    tick();
    chk("drain_en_b", 32'(enable), 32'd1);
    chk("drain_last", 32'(cur_phase), 32'h10);
    tick();
    chk("drain_off", 32'(enable), 32'd0);
    chk("drain_cnt", 32'(instr_cnt), 32'd3);
    chk("drain_nodone", 32'(step_done), 32'd0);

    // Stop exactly on a boundary -> straight to IDLE
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("stopb_phase", 32'(cur_phase), 32'h10);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stopb_enable", 32'(enable), 32'd0);
    chk("stopb_cnt", 32'(instr_cnt), 32'd4);
    tick();
    chk("stopb_idle", 32'(enable), 32'd0);

    // start and step together -> RUN (survives a boundary)
    start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("both_run", 32'(enable), 32'd1);
    chk("both_nodone", 32'(step_done), 32'd0);
    chk("both_cnt", 32'(instr_cnt), 32'd5);

    // Illegal phase codes in RUN
    ovr = 1'b1; ovr_val = 5'b00110; tick(); ovr = 1'b0;
    chk("perr_set", 32'(phase_err), 32'd1);
    chk("perr_cnt", 32'(instr_cnt), 32'd5);
    tick();
    chk("perr_sticky", 32'(phase_err), 32'd1);
    ovr = 1'b1; ovr_val = 5'b10001; tick(); ovr = 1'b0;
    chk("perr_nobnd", 32'(instr_cnt), 32'd5);
    chk("perr_run", 32'(enable), 32'd1);

    // Halt at a boundary
    wait_phase(5'b10000, ok);
    chk("halt_wait", 32'(ok), 32'd1);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_enable", 32'(enable), 32'd0);
    chk("halt_cnt", 32'(instr_cnt), 32'd6);
    start = 1'b1; tick(); start = 1'b0; tick();
    step  = 1'b1; tick(); step  = 1'b0; tick();
    stop  = 1'b1; tick(); stop  = 1'b0; tick();
    chk("halt_stuck", 32'(halted), 32'd1);
    chk("halt_stuck_en", 32'(enable), 32'd0);
    chk("halt_stuck_cnt", 32'(instr_cnt), 32'd6);

    // Asynchronous reset from HALT
    #2 rst_n = 1'b0;
    #1;
    chk("hrst_halted", 32'(halted), 32'd0);
    chk("hrst_enable", 32'(enable), 32'd0);
    chk("hrst_cnt", 32'(instr_cnt), 32'd0);
    chk("hrst_perr", 32'(phase_err), 32'd0);
    chk("hrst_done", 32'(step_done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a step abandons it
    step = 1'b1; tick(); step = 1'b0;
    tick(); tick();
    chk("mid_enable", 32'(enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_enable_rst", 32'(enable), 32'd0);
    chk("mid_cnt", 32'(instr_cnt), 32'd0);
    chk("mid_done", 32'(step_done), 32'd0);

    // start held through reset gives no pulse
    start = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("held_start", 32'(enable), 32'd0);
    start = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("wrap_run", 32'(enable), 32'd1);

    // 16 instructions: 4-bit counter wraps 15 -> 0
    for (int i = 0; i < 15; i++) begin
      wait_phase(5'b10000, ok);
      tick();
    end
    chk("wrap_cnt4_15", 32'(instr_cnt4), 32'd15);
    chk("wrap_cnt16_15", 32'(instr_cnt), 32'd15);
    wait_phase(5'b10000, ok);
    tick();
    chk("wrap_cnt4_0", 32'(instr_cnt4), 32'd0);
    chk("wrap_cnt16_16", 32'(instr_cnt), 32'd16);

    stop = 1'b1; tick(); stop = 1'b0;
    run_enable(n, d);
    chk("wrap_stop", 32'(enable), 32'd0);
    chk("wrap_final_cnt", 32'(instr_cnt), 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_control.md
RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the retired-instruction counter.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  level request to run freely; rising edge acts.
REQ-005 stop  input  1  level request to stop at the next instruction boundary; rising edge acts.
REQ-006 step  input  1  level request to execute exactly one instruction; rising edge acts.
REQ-007 halt_req  input  1  high while the instruction now in its last phase is a halt instruction.
REQ-008 cur_phase  input  5  one-hot phase from the phase counter: 00001, 00010, 00100, 01000, 10000, or 00000 after reset.
REQ-009 enable  output  1  advance enable to the phase counter.
REQ-010 halted  output  1  high in state HALT.
REQ-011 step_done  output  1  one-cycle pulse when a single step completes.
REQ-012 instr_cnt  output  CNT_W  count of retired instructions.
REQ-013 phase_err  output  1  sticky flag set on any illegal cur_phase value.

Function
REQ-014 The block SHALL edge-detect start/stop/step with one register each (start_p, stop_p, step_p = input high AND previous sample low); the previous-sample registers reset to 1, so a level held through reset gives no pulse.
REQ-015 The block SHALL implement states IDLE, RUN, STEP, DRAIN, HALT in a registered state variable.
REQ-016 enable SHALL be a pure decode of the state register: 1 in RUN, STEP, DRAIN; 0 in IDLE and HALT.
REQ-017 A boundary SHALL be the cycle where enable=1 and cur_phase=10000, i.e. the phase counter wraps to 00001 on the next edge.
REQ-018 IDLE: start_p -> RUN; else step_p -> STEP; stop_p and halt_req ignored.
REQ-019 RUN: boundary with halt_req=1 -> HALT; else stop_p -> IDLE if a boundary occurs in the same cycle, otherwise DRAIN; else stay.
REQ-020 DRAIN: boundary with halt_req=1 -> HALT; else boundary -> IDLE; else start_p -> RUN (stop cancelled).
REQ-021 STEP: boundary with halt_req=1 -> HALT; else boundary -> IDLE with step_done=1 for that one cycle; start_p, stop_p, step_p ignored.
REQ-022 HALT SHALL be exited only by reset; all requests are ignored.
REQ-023 instr_cnt SHALL increment by 1 on every boundary, including one that enters HALT; it wraps from 2^CNT_W-1 to 0.
REQ-024 phase_err SHALL set when cur_phase is nonzero and not one-hot, in any state; it clears only on reset.
REQ-025 An illegal cur_phase SHALL never count as a boundary.
REQ-026 From a phase counter just out of reset (00000), the first step SHALL keep enable high for 6 cycles; every later step takes exactly 5 cycles.
REQ-027 step_done SHALL be registered and SHALL assert on the edge after the boundary, coincident with enable falling.

Reset
REQ-028 With rst_n=0, the block SHALL immediately force: state IDLE, enable 0, halted 0, step_done 0, instr_cnt 0, phase_err 0, and edge-detect registers 1, regardless of clk.
REQ-029 Reset asserted mid-instruction SHALL abandon the instruction with no step_done pulse and no count.
REQ-030 Reset deassertion SHALL be followed by normal operation from the next rising edge.

Verification
REQ-031 Reset, then one step pulse with cur_phase driven by a model phase counter -> enable high 6 cycles, step_done one pulse, instr_cnt=1, then with a second step pulse -> enable high 5 cycles, instr_cnt=2.
REQ-032 start, then a stop pulse while cur_phase=00100 -> enable stays high until the cycle with cur_phase=10000, then drops; instr_cnt incremented by exactly 1 during the drain.
REQ-033 RUN with halt_req=1 at a cur_phase=10000 cycle -> halted=1 and enable=0 next cycle; later start, step, stop pulses -> no change; rst_n low -> all outputs 0.
REQ-034 stop pulse in the exact cycle cur_phase=10000 in RUN -> IDLE directly with DRAIN skipped; start and step pulsed together in IDLE -> RUN.
REQ-035 Drive cur_phase=00110 for one cycle in RUN -> phase_err=1 stays set, no boundary, and no instr_cnt change; with CNT_W=4, run 16 instructions -> instr_cnt wraps 15 -> 0.
